// File: rtl/ita_package.sv
// Shared constants and types for the ITA attention datapath (score lanes, tile geometry).
package ita_package;

  localparam int unsigned N          = 16;
  localparam int unsigned M          = 64;
  localparam int unsigned WI         = 8;
  localparam int unsigned TILE_BEATS = M * M / N;
  localparam int unsigned BEAT_W     = $clog2(TILE_BEATS);
  localparam int unsigned ROW_W      = $clog2(M);
  localparam int unsigned CNT_W      = $clog2(M * M + 1);
  localparam int unsigned POP_W      = $clog2(N + 1);

  // Most negative WI-bit score, i.e. -2^(WI-1): softmax weight rounds to zero.
  localparam logic signed [WI-1:0] MASK_NEG_VAL = {1'b1, {(WI-1){1'b0}}};

  typedef logic [BEAT_W-1:0] tile_beat_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  function automatic logic [POP_W-1:0] popcount(input logic [N-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ita_mask_row_tracker.sv
// Beat position / row-liveness tracker for one MxM tile of masked scores.
// Optional ITA_MASK_STATS_EN adds a per-tile masked-lane count.
module ita_mask_row_tracker
  import ita_package::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         accept_i,
  input  logic [N-1:0] em_i,
  output logic         tile_done_o,
  output logic [M-1:0] row_live_o
`ifdef ITA_MASK_STATS_EN
  ,
  output cnt_t         masked_cnt_o
`endif
);

  tile_beat_t          beat_r;
  logic [M-1:0]        row_acc_r;
  logic [M-1:0]        row_live_r;
  logic                tile_done_r;
  logic [M-1:0]        row_next_s;
  logic [ROW_W-1:0]    row_s;
  logic                last_s;

  assign row_s  = beat_r[ROW_W-1:0];
  assign last_s = (beat_r == tile_beat_t'(TILE_BEATS - 1));

  // Fold the current beat's liveness into its row; any unmasked lane keeps the row live.
  always_comb begin
    row_next_s        = row_acc_r;
    row_next_s[row_s] = row_acc_r[row_s] | ~(&em_i);
  end

  // Beat counter, row accumulator and end-of-tile publication.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_r      <= '0;
      row_acc_r   <= '0;
      row_live_r  <= '0;
      tile_done_r <= 1'b0;
    end else if (clear_i) begin
      beat_r      <= '0;
      row_acc_r   <= '0;
      tile_done_r <= 1'b0;
    end else begin
      tile_done_r <= 1'b0;
      if (accept_i) begin
        if (last_s) begin
          beat_r      <= '0;
          row_acc_r   <= '0;
          row_live_r  <= row_next_s;
          tile_done_r <= 1'b1;
        end else begin
          beat_r    <= beat_r + tile_beat_t'(1);
          row_acc_r <= row_next_s;
        end
      end
    end
  end

  assign tile_done_o = tile_done_r;
  assign row_live_o  = row_live_r;

`ifdef ITA_MASK_STATS_EN
  cnt_t run_cnt_r;
  cnt_t masked_cnt_r;
  cnt_t cnt_next_s;

  assign cnt_next_s = run_cnt_r + cnt_t'(popcount(em_i));

  // Running masked-lane count; published count survives clear like row_live.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt_r    <= '0;
      masked_cnt_r <= '0;
    end else if (clear_i) begin
      run_cnt_r <= '0;
    end else if (accept_i) begin
      if (last_s) begin
        run_cnt_r    <= '0;
        masked_cnt_r <= cnt_next_s;
      end else begin
        run_cnt_r <= cnt_next_s;
      end
    end
  end

  assign masked_cnt_o = masked_cnt_r;
`endif

endmodule

// File: rtl/ita_mask_apply.sv
// Applies the per-beat attention mask to QK score beats ahead of softmax.
// Optional ITA_MASK_STATS_EN exposes masked_cnt_o from the row tracker.
module ita_mask_apply
  import ita_package::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            mask_en_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [N*WI-1:0] data_i,
  input  logic [N-1:0]    mask_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [N*WI-1:0] data_o,
  output logic [N-1:0]    mask_o,
  output logic            tile_done_o,
  output logic [M-1:0]    row_live_o
`ifdef ITA_MASK_STATS_EN
  ,
  output cnt_t            masked_cnt_o
`endif
);

  logic [N-1:0]    em_s;
  logic [N*WI-1:0] masked_s;
  logic            accept_s;
  logic            valid_r;
  logic [N*WI-1:0] data_r;
  logic [N-1:0]    mask_r;

  assign em_s     = mask_en_i ? mask_i : '0;
  assign ready_o  = ~valid_r | ready_i;
  assign accept_s = valid_i & ready_o;

  // Replace masked lanes with the saturated minimum; others pass bit-exact.
  always_comb begin
    masked_s = data_i;
    for (int i = 0; i < N; i++) begin
      if (em_s[i]) begin
        masked_s[i*WI +: WI] = MASK_NEG_VAL;
      end else begin
        masked_s[i*WI +: WI] = data_i[i*WI +: WI];
      end
    end
  end

  // Single-entry output register; clear drops any beat presented alongside it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      mask_r  <= '0;
    end else if (clear_i) begin
      valid_r <= 1'b0;
    end else if (accept_s) begin
      valid_r <= 1'b1;
      data_r  <= masked_s;
      mask_r  <= em_s;
    end else if (ready_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid_o = valid_r;
  assign data_o  = data_r;
  assign mask_o  = mask_r;

  ita_mask_row_tracker u_tracker (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .accept_i     (accept_s),
    .em_i         (em_s),
    .tile_done_o  (tile_done_o),
    .row_live_o   (row_live_o)
`ifdef ITA_MASK_STATS_EN
    ,
    .masked_cnt_o (masked_cnt_o)
`endif
  );

endmodule

// File: tb/tb_ita_mask_apply.sv
// Directed self-checking bench for ita_mask_apply (ITA_MASK_STATS_EN adds count checks).
module tb_ita_mask_apply;
  import ita_package::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            mask_en;
  logic            valid_in;
  logic            ready_out;
  logic [N*WI-1:0] data_in;
  logic [N-1:0]    mask_in;
  logic            valid_out;
  logic            ready_in;
  logic [N*WI-1:0] data_out;
  logic [N-1:0]    mask_out;
  logic            tile_done;
  logic [M-1:0]    row_live;
`ifdef ITA_MASK_STATS_EN
  cnt_t            masked_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ita_mask_apply dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .mask_en_i   (mask_en),
    .valid_i     (valid_in),
    .ready_o     (ready_out),
    .data_i      (data_in),
    .mask_i      (mask_in),
    .valid_o     (valid_out),
    .ready_i     (ready_in),
    .data_o      (data_out),
    .mask_o      (mask_out),
    .tile_done_o (tile_done),
    .row_live_o  (row_live)
`ifdef ITA_MASK_STATS_EN
    ,
    .masked_cnt_o (masked_cnt)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] tri_mask(input int b);
    logic [N-1:0] m;
    int r;
    int g;
    r = b % M;
    g = b / M;
    m = '0;
    for (int i = 0; i < N; i++) begin
      if (g * N + i < r) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [N*WI-1:0] gen_data(input int b);
    logic [N*WI-1:0] d;
    for (int i = 0; i < N; i++) d[i*WI +: WI] = 8'(b * 7 + i * 13 + 1);
    return d;
  endfunction

  function automatic logic [N*WI-1:0] apply_mask(input logic [N*WI-1:0] d, input logic [N-1:0] m);
    logic [N*WI-1:0] o;
    for (int i = 0; i < N; i++) o[i*WI +: WI] = m[i] ? 8'h80 : d[i*WI +: WI];
    return o;
  endfunction

  task automatic drive(input int b, input logic [N-1:0] m);
    valid_in = 1'b1;
    data_in  = gen_data(b);
    mask_in  = m;
  endtask

  // Accept one beat with ready_in high and check the registered result.
  task automatic beat_step(input string tag, input int b, input logic [N-1:0] m, input logic done_exp);
    drive(b, m);
    tick();
    check({tag, "_valid"}, 128'(valid_out), 128'(1'b1));
    check({tag, "_data"}, 128'(data_out), 128'(apply_mask(gen_data(b), m)));
    check({tag, "_mask"}, 128'(mask_out), 128'(m));
    check({tag, "_done"}, 128'(tile_done), 128'(done_exp));
  endtask

  logic [N-1:0] m;

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    mask_en  = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b1;
    data_in  = '0;
    mask_in  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_valid", 128'(valid_out), 128'(1'b0));
    check("rst_data", 128'(data_out), 128'(0));
    check("rst_mask", 128'(mask_out), 128'(0));
    check("rst_done", 128'(tile_done), 128'(1'b0));
    check("rst_live", 128'(row_live), 128'(0));
    check("rst_ready", 128'(ready_out), 128'(1'b1));

    // Lane masking: lanes 0-7 forced to 0x80.
    valid_in = 1'b1;
    data_in  = {16{8'h05}};
    mask_in  = 16'h00FF;
    tick();
    check("mask_data", 128'(data_out), 128'h0505_0505_0505_0505_8080_8080_8080_8080);
    check("mask_mask", 128'(mask_out), 128'(16'h00FF));
    check("mask_valid", 128'(valid_out), 128'(1'b1));

    // Bypass with mask_en low.
    mask_en = 1'b0;
    tick();
    check("byp_data", 128'(data_out), 128'h0505_0505_0505_0505_0505_0505_0505_0505);
    check("byp_mask", 128'(mask_out), 128'(16'h0000));
    mask_en = 1'b1;

    // Flush the two stray beats so the tile starts at beat 0.
    valid_in = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    check("clr0_valid", 128'(valid_out), 128'(1'b0));
    check("clr0_live", 128'(row_live), 128'(0));

    // Tile 1: upper-triangular mask with backpressure on beats 0/1 and a gap at 128.
    beat_step("t1b0", 0, tri_mask(0), 1'b0);
    ready_in = 1'b0;
    drive(1, tri_mask(1));
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", 128'(ready_out), 128'(1'b0));
      tick();
      check("bp_valid", 128'(valid_out), 128'(1'b1));
      check("bp_data", 128'(data_out), 128'(apply_mask(gen_data(0), tri_mask(0))));
      check("bp_done", 128'(tile_done), 128'(1'b0));
    end
    ready_in = 1'b1;
    #1;
    check("bp_release_ready", 128'(ready_out), 128'(1'b1));
    beat_step("t1b1", 1, tri_mask(1), 1'b0);
    for (int b = 2; b < TILE_BEATS; b++) begin
      if (b == 128) begin
        valid_in = 1'b0;
        tick();
        check("gap_valid", 128'(valid_out), 128'(1'b0));
      end
      beat_step("t1", b, tri_mask(b), (b == TILE_BEATS - 1));
    end
    check("t1_live", 128'(row_live), 128'({M{1'b1}}));
`ifdef ITA_MASK_STATS_EN
    check("t1_cnt", 128'(masked_cnt), 128'(2016));
`endif
    valid_in = 1'b0;
    tick();
    check("t1_done_low", 128'(tile_done), 128'(1'b0));
    check("t1_drain", 128'(valid_out), 128'(1'b0));

    // Tile 2: same, with row 63 fully masked.
    for (int b = 0; b < TILE_BEATS; b++) begin
      m = tri_mask(b);
      if (b % M == M - 1) m = '1;
      beat_step("t2", b, m, (b == TILE_BEATS - 1));
      if (b == 100) check("t2_live_held", 128'(row_live), 128'({M{1'b1}}));
    end
    check("t2_live", 128'(row_live), 128'(64'h7FFF_FFFF_FFFF_FFFF));
`ifdef ITA_MASK_STATS_EN
    check("t2_cnt", 128'(masked_cnt), 128'(2017));
`endif

    // Clear at beat 100: live pre-clear beats must not leak into the next tile.
    for (int b = 0; b < 100; b++) beat_step("pre", b, '0, 1'b0);
    drive(100, '0);
    clear = 1'b1;
    #1;
    check("clr_ready", 128'(ready_out), 128'(1'b1));
    tick();
    clear    = 1'b0;
    valid_in = 1'b0;
    check("clr_valid", 128'(valid_out), 128'(1'b0));
    check("clr_done", 128'(tile_done), 128'(1'b0));
    check("clr_live_kept", 128'(row_live), 128'(64'h7FFF_FFFF_FFFF_FFFF));
    for (int b = 0; b < TILE_BEATS; b++) begin
      m = (b % M == 5) ? 16'hFFFE : 16'hFFFF;
      beat_step("t3", b, m, (b == TILE_BEATS - 1));
    end
    check("t3_live", 128'(row_live), 128'(64'h20));
`ifdef ITA_MASK_STATS_EN
    check("t3_cnt", 128'(masked_cnt), 128'(4092));

    // One masked lane per beat.
    for (int b = 0; b < TILE_BEATS; b++) beat_step("t4", b, 16'h0001, (b == TILE_BEATS - 1));
    check("t4_cnt", 128'(masked_cnt), 128'(256));
    check("t4_live", 128'(row_live), 128'({M{1'b1}}));
`endif
    valid_in = 1'b0;
    tick();
    check("end_done_low", 128'(tile_done), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
